// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction controller: counter encodings,
// FSM states and the 2-bit saturating counter update.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'b01;
        end
        return (cnt == SNT) ? SNT : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/bp_pend_fifo.sv
// In-order FIFO of in-flight predictions. clear wins over push/pop; the caller
// never pushes when full nor pops when empty.
module bp_pend_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bp_ctrl.sv
// Branch-prediction controller: 2-bit counter table queried in ID, updated in
// order at EX resolution, with a one-cycle redirect on mispredict.
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             query_valid,
    input  logic [31:0]      query_pc,
    input  logic [31:0]      query_target,
    input  logic [31:0]      query_fallthru,
    output logic             query_ready,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_count
);

    localparam int ENT_W = IDX_W + 1 + 32;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] init_idx;
    logic [1:0]       ctr [2**IDX_W];

    logic [IDX_W-1:0] idx;
    logic             push, pop, mispredict;
    logic [ENT_W-1:0] fifo_din, fifo_dout;
    logic [IDX_W-1:0] head_idx;
    logic             head_pred;
    logic [31:0]      head_rpc;
    logic             fifo_full, fifo_empty;
    logic             unused_pc;

    assign idx       = query_pc[IDX_W+1:2];
    assign unused_pc = ^{query_pc[31:IDX_W+2], query_pc[1:0]};

    assign pred_taken = ctr[idx][1];
    assign pred_pc    = pred_taken ? query_target : query_fallthru;

    // Handshake: a query transfers on a cycle where query_valid && query_ready;
    // query_ready never depends on query_valid and drops when the FIFO is full
    // even if a pop happens in that same cycle.
    assign query_ready = (state == RUN) && !stall && !fifo_full;
    assign push        = query_valid && query_ready;
    assign pop         = resolve_valid && (state == RUN) && !stall && !fifo_empty;
    assign mispredict  = pop && (resolve_taken != head_pred);

    // The entry stores the PC of the path not predicted, used on recovery.
    assign fifo_din  = {idx, pred_taken, (pred_taken ? query_fallthru : query_target)};
    assign head_idx  = fifo_dout[ENT_W-1 -: IDX_W];
    assign head_pred = fifo_dout[32];
    assign head_rpc  = fifo_dout[31:0];

    bp_pend_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (mispredict),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (dbg_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_idx == '1) state_nxt = RUN;
            RUN:     if (mispredict) state_nxt = RECOVER;
            RECOVER: state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT;
            init_idx    <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state    <= state_nxt;
            redirect <= mispredict;
            if (state == INIT) init_idx <= init_idx + 1'b1;
            if (mispredict) redirect_pc <= head_rpc;
        end
    end

    // Sweep overwrites every entry after reset, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            ctr[init_idx] <= WT;
        end else if (pop) begin
            ctr[head_idx] <= sat_update(ctr[head_idx], resolve_taken);
        end
    end

    assign busy      = (state == INIT);
    assign dbg_state = state;

endmodule

// File: tb/tb_bp_ctrl.sv
// Bench for bp_ctrl: vector table for the main flow, hand sequences for reset
// and the initialisation sweep, and a redirect scoreboard.
module tb_bp_ctrl;
    import bp_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, query_valid, resolve_valid, resolve_taken;
    logic [31:0] query_pc, query_target, query_fallthru;
    logic        query_ready, pred_taken, redirect, busy;
    logic [31:0] pred_pc, redirect_pc;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bp_ctrl #(.IDX_W(6), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .query_valid    (query_valid),
        .query_pc       (query_pc),
        .query_target   (query_target),
        .query_fallthru (query_fallthru),
        .query_ready    (query_ready),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .dbg_state      (dbg_state),
        .dbg_count      (dbg_count)
    );

    typedef struct {
        logic        qv;
        logic [31:0] pc;
        logic        rv;
        logic        rt;
        logic        st;
        logic        rdy;
        logic        pred;
        logic [2:0]  cnt;
        logic [1:0]  stt;
        logic [31:0] rpc;   // expected redirect_pc, 0 = no redirect expected
    } vec_t;

    localparam logic [31:0] P  = 32'h0040_0010;
    localparam logic [31:0] A0 = 32'h0040_0020;
    localparam logic [31:0] A1 = 32'h0040_0024;
    localparam logic [31:0] A2 = 32'h0040_0028;
    localparam logic [31:0] A3 = 32'h0040_002C;
    localparam logic [31:0] A4 = 32'h0040_0030;
    localparam logic [1:0]  S_INIT = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_REC  = 2'd2;

    vec_t vecs[$];
    vec_t post[$];

    function automatic vec_t mk(logic qv, logic [31:0] pc, logic rv, logic rt, logic st,
                                logic rdy, logic pred, logic [2:0] cnt, logic [1:0] stt,
                                logic [31:0] rpc);
        vec_t v;
        v.qv = qv; v.pc = pc; v.rv = rv; v.rt = rt; v.st = st;
        v.rdy = rdy; v.pred = pred; v.cnt = cnt; v.stt = stt; v.rpc = rpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        query_valid = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0; stall = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        query_valid    = v.qv;
        query_pc       = v.pc;
        query_target   = v.pc + 32'h0000_00F0;
        query_fallthru = v.pc + 32'h0000_0004;
        resolve_valid  = v.rv;
        resolve_taken  = v.rt;
        stall          = v.st;
        if (v.rpc != 32'h0) exp_q.push_back(v.rpc);
        #2;
        chk({tag, "_ready"}, 32'(query_ready), 32'(v.rdy));
        if (v.qv) begin
            chk({tag, "_pred"}, 32'(pred_taken), 32'(v.pred));
            chk({tag, "_pred_pc"}, pred_pc, v.pred ? query_target : query_fallthru);
        end
        step();
        chk({tag, "_count"}, 32'(dbg_count), 32'(v.cnt));
        chk({tag, "_state"}, 32'(dbg_state), 32'(v.stt));
    endtask

    // Holds a query on the bus throughout the sweep; it must never be accepted.
    task automatic wait_init(input string tag);
        int n = 0;
        int bad_ready = 0;
        query_valid = 1'b1; query_pc = P;
        query_target = P + 32'h0000_00F0; query_fallthru = P + 32'h0000_0004;
        while (busy && n < 200) begin
            if (query_ready) bad_ready++;
            step();
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd64);
        chk({tag, "_ready_in_init"}, 32'(bad_ready), 32'd0);
        chk({tag, "_count_after_init"}, 32'(dbg_count), 32'd0);
        idle();
    endtask

    always @(negedge clk) begin
        if (!reset && redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got redirect_pc %0h, required no redirect", redirect_pc);
            end else begin
                chk("redirect_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back(mk(1, P,  0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(0, P,  1, 1, 0, 1, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, P,  0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(0, P,  1, 1, 0, 1, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, P,  0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(0, P,  1, 0, 0, 1, 0, 0, S_REC, 32'h0040_0014));
        vecs.push_back(mk(1, P,  0, 0, 0, 0, 1, 0, S_RUN, 0));
        vecs.push_back(mk(1, P,  0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(0, P,  1, 0, 0, 1, 0, 0, S_REC, 32'h0040_0014));
        vecs.push_back(mk(1, P,  0, 0, 1, 0, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, P,  0, 0, 0, 1, 0, 1, S_RUN, 0));
        vecs.push_back(mk(0, P,  1, 0, 0, 1, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, P,  0, 0, 0, 1, 0, 1, S_RUN, 0));
        vecs.push_back(mk(0, P,  1, 0, 0, 1, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, P,  0, 0, 1, 0, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, P,  0, 0, 0, 1, 0, 1, S_RUN, 0));
        vecs.push_back(mk(0, P,  1, 1, 0, 1, 0, 0, S_REC, 32'h0040_0100));
        vecs.push_back(mk(1, P,  0, 0, 1, 0, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, A0, 0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(1, A1, 0, 0, 0, 1, 1, 2, S_RUN, 0));
        vecs.push_back(mk(1, A2, 0, 0, 0, 1, 1, 3, S_RUN, 0));
        vecs.push_back(mk(1, A3, 0, 0, 0, 1, 1, 4, S_RUN, 0));
        vecs.push_back(mk(1, A4, 1, 1, 0, 0, 1, 3, S_RUN, 0));
        vecs.push_back(mk(0, A4, 1, 1, 0, 1, 0, 2, S_RUN, 0));
        vecs.push_back(mk(0, A4, 1, 1, 0, 1, 0, 1, S_RUN, 0));
        vecs.push_back(mk(0, A4, 1, 1, 0, 1, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, A0, 0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(1, A1, 1, 0, 0, 1, 1, 0, S_REC, 32'h0040_0024));
        vecs.push_back(mk(1, A1, 0, 0, 0, 0, 1, 0, S_RUN, 0));
        vecs.push_back(mk(1, A0, 0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(1, A1, 1, 0, 1, 0, 1, 1, S_RUN, 0));
        vecs.push_back(mk(1, A1, 1, 0, 1, 0, 1, 1, S_RUN, 0));
        vecs.push_back(mk(0, A0, 1, 1, 0, 1, 0, 0, S_RUN, 0));
        vecs.push_back(mk(0, A0, 1, 0, 0, 1, 0, 0, S_RUN, 0));
        vecs.push_back(mk(1, A0, 0, 0, 0, 1, 1, 1, S_RUN, 0));
        vecs.push_back(mk(0, A0, 1, 0, 0, 1, 0, 0, S_REC, 32'h0040_0024));
        vecs.push_back(mk(1, A0, 0, 0, 1, 0, 1, 0, S_RUN, 0));
        vecs.push_back(mk(1, A0, 0, 0, 0, 1, 1, 1, S_RUN, 0));

        post.push_back(mk(1, P,  0, 0, 1, 0, 1, 0, S_RUN, 0));
        post.push_back(mk(1, P,  0, 0, 0, 1, 1, 1, S_RUN, 0));
        post.push_back(mk(0, P,  1, 0, 0, 1, 0, 0, S_REC, 32'h0040_0014));
        post.push_back(mk(1, P,  0, 0, 1, 0, 0, 0, S_RUN, 0));

        reset = 1'b1;
        query_pc = '0; query_target = '0; query_fallthru = '0;
        idle();
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(query_ready), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_INIT));
        chk("rst_count", 32'(dbg_count), 32'd0);
        reset = 1'b0;
        wait_init("init1");

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));
        idle();

        // Reset in the middle of RUN with an entry pending and idx 4 at WNT.
        reset = 1'b1;
        step();
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_state", 32'(dbg_state), 32'(S_INIT));
        chk("mid_rst_count", 32'(dbg_count), 32'd0);
        reset = 1'b0;
        wait_init("init2");

        begin
            int not_taken = 0;
            stall = 1'b1;
            query_valid = 1'b1;
            for (int i = 0; i < 64; i++) begin
                query_pc = 32'h0040_0000 + 32'(i * 4);
                #1;
                if (pred_taken !== 1'b1) not_taken++;
            end
            chk("sweep_all_taken", 32'(not_taken), 32'd0);
            idle();
            step();
        end

        // WT (not ST) after the sweep: one not-taken resolve flips the prediction.
        for (int i = 0; i < post.size(); i++) apply(post[i], $sformatf("p%0d", i));
        idle();
        step();
        step();
        chk("redirect_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
